// File: rtl/sift_window_sequencer_if.sv
// Bundle between the frame source, the sequencer and the SIFT window datapath:
// pixel handshake in, window shift controls and centre tags out.
interface sift_window_sequencer_if #(
    parameter int CW      = 16,
    parameter int OCTAVES = 3
) ();
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_pix;
    logic               win_shift;
    logic [7:0]         win_pix;
    logic [CW-1:0]      ctr_x;
    logic [CW-1:0]      ctr_y;
    logic               ctr_upd;
    logic               ctr_valid;
    logic [OCTAVES-1:0] oct_en;
    logic               sof;
    logic               eof;
    logic               busy;
    logic               frame_done;

    // Frame source / consumer side
    modport master (
        output start, in_valid, in_pix,
        input  in_ready, win_shift, win_pix, ctr_x, ctr_y, ctr_upd, ctr_valid,
               oct_en, sof, eof, busy, frame_done
    );

    // Sequencer side
    modport slave (
        input  start, in_valid, in_pix,
        output in_ready, win_shift, win_pix, ctr_x, ctr_y, ctr_upd, ctr_valid,
               oct_en, sof, eof, busy, frame_done
    );
endinterface

// File: rtl/sift_window_sequencer.sv
// Frame sequencer for the SIFT window datapath. Feeds one raster frame into the
// window shift register, then shifts in zeros until the last real pixel reaches
// the centre tap, and tags each window output with its centre coordinate.
//
// state | meaning
// IDLE  | waiting for start; no shifts, in_ready low
// RUN   | accepting pixels; each accept shifts the window one step
// FLUSH | shifting in zero pixels, LAT steps, to drain the window
// DONE  | waiting for the final centre tag (eof), then pulse frame_done
module sift_window_sequencer #(
    parameter int FRAME_W  = 200,
    parameter int FRAME_H  = 200,
    parameter int WIN_RADI = 1,
    parameter int OCTAVES  = 3,
    parameter int CW       = 16
) (
    input  logic                    pixClk,
    input  logic                    rst_n,
    sift_window_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Shifts needed for a pixel to travel from the window input to the centre tap.
    localparam int LAT = WIN_RADI * FRAME_W + WIN_RADI;

    localparam logic [CW-1:0] X_LAST     = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(FRAME_H - 1);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(LAT);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(LAT - 1);
    localparam logic [CW-1:0] R_LO       = CW'(WIN_RADI);
    localparam logic [CW-1:0] X_HI       = CW'(FRAME_W - 1 - WIN_RADI);
    localparam logic [CW-1:0] Y_HI       = CW'(FRAME_H - 1 - WIN_RADI);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_in_x;
    logic [CW-1:0]      r_in_y;
    logic [CW-1:0]      r_flush_cnt;
    logic [CW-1:0]      r_lat_cnt;
    logic [CW-1:0]      r_cx;
    logic [CW-1:0]      r_cy;
    logic               r_win_shift;
    logic [7:0]         r_win_pix;
    logic [CW-1:0]      r_ctr_x;
    logic [CW-1:0]      r_ctr_y;
    logic               r_ctr_upd;
    logic               r_ctr_valid;
    logic [OCTAVES-1:0] r_oct_en;
    logic               r_sof;
    logic               r_eof;
    logic               r_frame_done;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_in_last;
    logic               w_flush_step;
    logic               w_start;
    logic               w_ctr_adv;
    logic               w_cvalid;
    logic [OCTAVES-1:0] w_oct;
    logic [CW-1:0]      w_mask;

    assign w_in_ready   = (r_state == S_RUN);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_in_last    = (r_in_x == X_LAST) && (r_in_y == Y_LAST);
    assign w_flush_step = (r_state == S_FLUSH);
    assign w_start      = bus.start && (r_state == S_IDLE);
    // Latency counter at zero means the window is primed: every shift now moves the centre.
    assign w_ctr_adv    = r_win_shift && (r_lat_cnt == '0);
    assign w_cvalid     = (r_cx >= R_LO) && (r_cx <= X_HI) && (r_cy >= R_LO) && (r_cy <= Y_HI);

    // Per-octave decimation: centre coordinates must both be multiples of 2**k.
    always_comb begin
        w_oct  = '0;
        w_mask = '0;
        for (int k = 0; k < OCTAVES; k++) begin
            w_mask   = (CW'(1) << k) - CW'(1);
            w_oct[k] = w_cvalid && ((r_cx & w_mask) == '0) && ((r_cy & w_mask) == '0);
        end
    end

    // Frame FSM with input raster counters and flush down-counter.
    always_ff @(posedge pixClk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_x       <= '0;
            r_in_y       <= '0;
            r_flush_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_in_x  <= '0;
                        r_in_y  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_in_last) begin
                            r_state     <= S_FLUSH;
                            r_in_x      <= '0;
                            r_in_y      <= '0;
                            r_flush_cnt <= FLUSH_LOAD;
                        end else if (r_in_x == X_LAST) begin
                            r_in_x <= '0;
                            r_in_y <= r_in_y + CW'(1);
                        end else begin
                            r_in_x <= r_in_x + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - CW'(1);
                    end
                end
                default: begin
                    // The last flush shift still has to surface as the eof tag.
                    if (r_ctr_upd && r_eof) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered window shift strobe and pixel (zeros while flushing).
    always_ff @(posedge pixClk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_shift <= 1'b0;
            r_win_pix   <= '0;
        end else begin
            r_win_shift <= w_accept || w_flush_step;
            r_win_pix   <= w_accept ? bus.in_pix : 8'd0;
        end
    end

    // Centre tracking: latency down-counter, then raster centre counters.
    always_ff @(posedge pixClk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else if (w_start) begin
            r_lat_cnt <= LAT_LOAD;
            r_cx      <= '0;
            r_cy      <= '0;
        end else if (r_win_shift) begin
            if (r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - CW'(1);
            end else if (r_cx == X_LAST) begin
                r_cx <= '0;
                r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + CW'(1);
            end else begin
                r_cx <= r_cx + CW'(1);
            end
        end
    end

    // Centre tags, registered one cycle after the producing shift; held between updates.
    always_ff @(posedge pixClk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr_upd   <= 1'b0;
            r_ctr_x     <= '0;
            r_ctr_y     <= '0;
            r_ctr_valid <= 1'b0;
            r_oct_en    <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_ctr_upd <= w_ctr_adv;
            r_sof     <= w_ctr_adv && (r_cx == '0) && (r_cy == '0);
            r_eof     <= w_ctr_adv && (r_cx == X_LAST) && (r_cy == Y_LAST);
            if (w_ctr_adv) begin
                r_ctr_x     <= r_cx;
                r_ctr_y     <= r_cy;
                r_ctr_valid <= w_cvalid;
                r_oct_en    <= w_oct;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.win_shift  = r_win_shift;
    assign bus.win_pix    = r_win_pix;
    assign bus.ctr_x      = r_ctr_x;
    assign bus.ctr_y      = r_ctr_y;
    assign bus.ctr_upd    = r_ctr_upd;
    assign bus.ctr_valid  = r_ctr_valid;
    assign bus.oct_en     = r_oct_en;
    assign bus.sof        = r_sof;
    assign bus.eof        = r_eof;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_sift_window_sequencer.sv
// Scoreboard bench for sift_window_sequencer on an 8x6 frame with radius 1.
module tb_sift_window_sequencer;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int R   = 1;
    localparam int N   = W * H;
    localparam int LAT = R * W + R;

    typedef struct {
        int       x;
        int       y;
        bit       v;
        bit [2:0] oct;
        bit       sof;
        bit       eof;
    } tag_t;

    logic pixClk = 1'b0;
    logic rst_n  = 1'b0;

    sift_window_sequencer_if #(.CW(16), .OCTAVES(3)) bus ();

    sift_window_sequencer #(
        .FRAME_W(W), .FRAME_H(H), .WIN_RADI(R), .OCTAVES(3), .CW(16)
    ) dut (
        .pixClk (pixClk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 pixClk = ~pixClk;

    tag_t       q_tag[$];
    logic [7:0] q_pix[$];
    logic [7:0] hist[$];
    logic [7:0] mem[N];

    int n_checks = 0;
    int n_fail   = 0;
    int n_shift, n_upd, n_valid, n_oct0, n_oct1, n_oct2, n_done;
    bit prev_eof  = 1'b0;
    bit ramp_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference tag for raster index i, straight from the coordinate rules.
    function automatic tag_t make_tag(input int i);
        tag_t t;
        t.x   = i % W;
        t.y   = i / W;
        t.v   = (t.x >= R) && (t.x <= W - 1 - R) && (t.y >= R) && (t.y <= H - 1 - R);
        for (int k = 0; k < 3; k++)
            t.oct[k] = t.v && (t.x % (1 << k) == 0) && (t.y % (1 << k) == 0);
        t.sof = (i == 0);
        t.eof = (i == N - 1);
        return t;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a shift or a centre tag.
    always @(negedge pixClk) begin
        if (rst_n) begin
            if (bus.frame_done) begin
                n_done++;
                check("frame_done_after_eof", 64'(prev_eof), 64'(1));
                check("tags_drained_at_done", 64'(q_tag.size()), 64'(0));
            end
            prev_eof = bus.ctr_upd && bus.eof;
            if (bus.ctr_upd) begin
                n_upd++;
                if (bus.ctr_valid) n_valid++;
                if (bus.oct_en[0]) n_oct0++;
                if (bus.oct_en[1]) n_oct1++;
                if (bus.oct_en[2]) n_oct2++;
                check("ctr_upd_expected", 64'(q_tag.size() > 0), 64'(1));
                if (q_tag.size() > 0) begin
                    tag_t       e;
                    logic [7:0] tap;
                    e = q_tag.pop_front();
                    check("ctr_tag",
                          64'({bus.ctr_x, bus.ctr_y, bus.ctr_valid, bus.oct_en, bus.sof, bus.eof}),
                          64'({16'(e.x), 16'(e.y), e.v, e.oct, e.sof, e.eof}));
                    if (hist.size() > LAT) begin
                        tap = hist[hist.size() - 1 - LAT];
                        check("centre_tap", 64'(tap), 64'(mem[e.y * W + e.x]));
                        if (ramp_mode && e.x == 3 && e.y == 2)
                            check("centre_tap_3_2", 64'(tap), 64'(19));
                    end
                end
            end
            if (bus.win_shift) begin
                n_shift++;
                check("win_shift_expected", 64'(q_pix.size() > 0), 64'(1));
                if (q_pix.size() > 0)
                    check("win_pix", 64'(bus.win_pix), 64'(q_pix.pop_front()));
                hist.push_back(bus.win_pix);
            end
        end
    end

    task automatic tick();
        @(posedge pixClk);
        #1;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. abort_at>0 resets after that many accepts.
    task automatic run_frame(input int vmode, input bit start_poke, input int abort_at);
        int acc;
        int cyc;
        n_shift = 0; n_upd = 0; n_valid = 0; n_oct0 = 0; n_oct1 = 0; n_oct2 = 0; n_done = 0;
        hist.delete();
        bus.start = 1'b1;
        for (int i = 0; i < N; i++) q_tag.push_back(make_tag(i));
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'(1));
        acc = 0;
        cyc = 0;
        while (acc < N && cyc < 2000) begin
            if (abort_at > 0 && acc == abort_at) break;
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_pix = bus.in_valid ? mem[acc] : 8'($urandom);
            bus.start  = start_poke && (acc == 10);
            if (bus.in_valid && bus.in_ready) begin
                q_pix.push_back(mem[acc]);
                acc++;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        if (abort_at > 0 && acc == abort_at) begin
            rst_n        = 1'b0;
            bus.in_valid = 1'b0;
            #1;
            check("reset_outputs_zero",
                  64'({bus.win_shift, bus.win_pix, bus.ctr_x, bus.ctr_y, bus.ctr_upd,
                       bus.ctr_valid, bus.oct_en, bus.sof, bus.eof, bus.frame_done}),
                  64'(0));
            check("reset_in_ready", 64'(bus.in_ready), 64'(0));
            check("reset_busy", 64'(bus.busy), 64'(0));
            q_tag.delete();
            q_pix.delete();
            hist.delete();
            prev_eof = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
            return;
        end
        check("all_pixels_accepted", 64'(acc), 64'(N));
        for (int i = 0; i < LAT; i++) q_pix.push_back(8'd0);
        bus.in_valid = 1'b1;
        bus.in_pix   = 8'($urandom);
        if (start_poke) begin
            tick();
            tick();
            tick();
            check("busy_in_flush", 64'(bus.busy), 64'(1));
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        cyc = 0;
        while (n_done == 0 && cyc < 200) begin
            check("in_ready_low_after_run", 64'(bus.in_ready), 64'(0));
            tick();
            cyc++;
        end
        for (int i = 0; i < 6; i++) begin
            check("idle_in_ready_low", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.in_valid = 1'b0;
        check("frame_done_once", 64'(n_done), 64'(1));
        check("busy_idle", 64'(bus.busy), 64'(0));
        check("win_shift_count", 64'(n_shift), 64'(N + LAT));
        check("ctr_upd_count", 64'(n_upd), 64'(N));
        check("ctr_valid_count", 64'(n_valid), 64'(24));
        check("oct0_count", 64'(n_oct0), 64'(24));
        check("oct1_count", 64'(n_oct1), 64'(6));
        check("oct2_count", 64'(n_oct2), 64'(1));
        check("pix_queue_empty", 64'(q_pix.size()), 64'(0));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pix   = 8'd0;
        #1;
        check("reset_state",
              64'({bus.in_ready, bus.win_shift, bus.win_pix, bus.ctr_x, bus.ctr_y, bus.ctr_upd,
                   bus.ctr_valid, bus.oct_en, bus.sof, bus.eof, bus.busy, bus.frame_done}),
              64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pix   = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_ignores_valid", 64'(bus.in_ready), 64'(0));
        end

        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_frame(0, 1'b0, 0);
        run_frame(1, 1'b0, 0);

        ramp_mode = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        run_frame(2, 1'b1, 0);
        ramp_mode = 1'b0;

        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_frame(0, 1'b0, 20);
        run_frame(0, 1'b0, 0);
        run_frame(2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
